// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch unit.
package fetch_pkg;
  localparam int FETCH_DEFAULT_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, REQUEST, DRAIN, FAULT} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory read handshake between fetch unit (master) and memory (slave).
interface fetch_if;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master(output mem_read, mem_address, input mem_ready, mem_rdata);
  modport slave(input mem_read, mem_address, output mem_ready, mem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of fetched entries; head is zero whenever the buffer is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEFAULT_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd_data = empty ? '0 : mem[rptr];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clock)
    if (do_push && !flush) mem[wptr] <= wr_data;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM driving the memory handshake into a prefetch buffer.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned fetch addresses instead of aligning them.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int BUFFER_DEPTH = FETCH_DEFAULT_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  input  logic        flush,
  fetch_if.master     mem,
  output logic        pc_write,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        decode_ready,
  output logic        fetch_fault
);
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  fetch_state_e state, state_n;
  logic fresh, fresh_n, launch, misalign, hold, pop, full, empty;
  logic [31:0] addr_q, launch_addr;
  logic [CW-1:0] count, after_push;
  fetch_entry_t head;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = |fetch_address[1:0];
  assign launch_addr = fetch_address;
  assign fetch_fault = state == FAULT;
`else
  logic unused_lsbs;
  assign unused_lsbs = &{1'b0, fetch_address[1:0]};
  assign misalign = 1'b0;
  assign launch_addr = {fetch_address[31:2], 2'b00};
  assign fetch_fault = 1'b0;
`endif
  // fresh marks the first cycle of a request, when the address comes straight from the PC
  assign launch = state == REQUEST && fresh;
  assign mem.mem_read = state == DRAIN || (state == REQUEST && !(fresh && misalign));
  assign mem.mem_address = launch ? launch_addr : addr_q;
  assign hold = mem.mem_read && !mem.mem_ready;
  assign pc_write = state == REQUEST && mem.mem_read && mem.mem_ready && !flush;
  assign pop = instruction_valid && decode_ready;
  assign after_push = count + CW'(1) - CW'(pop);
  assign instruction_valid = !empty;
  assign instruction = head.instruction;
  assign instruction_pc = head.pc;
  assign fresh_n = state_n == REQUEST && !(state == REQUEST && hold);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (flush || !full || pop) ? REQUEST : IDLE;
      REQUEST: state_n = flush ? (hold ? DRAIN : REQUEST)
                       : (launch && misalign) ? FAULT
                       : (pc_write && after_push >= DEPTH_C) ? IDLE : REQUEST;
      DRAIN:   state_n = mem.mem_ready ? REQUEST : DRAIN;
      default: state_n = flush ? REQUEST : FAULT;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      fresh <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      fresh <= fresh_n;
      addr_q <= mem.mem_address;
    end
  fetch_fifo #(.DEPTH(BUFFER_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(pc_write),
    .pop(pop),
    .flush(flush),
    .wr_data('{pc: mem.mem_address, instruction: mem.mem_rdata}),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 2, prefetch buffer entries (power of two, 2..8).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fetch_address  input  32  program counter address bus, sampled when a request launches.
REQ-005 SHALL have port flush  input  1  redirect; discards buffer and in-flight response.
REQ-006 SHALL have ports mem_read output 1 / mem_address output 32 / mem_ready input 1 / mem_rdata input 32  instruction memory read handshake.
REQ-007 SHALL have port pc_write  output  1  one-cycle pulse advancing the program counter.
REQ-008 SHALL have ports instruction output 32 / instruction_pc output 32 / instruction_valid output 1 / decode_ready input 1  decode handshake.
REQ-009 SHALL have port fetch_fault  output  1  misaligned-fetch indication.

Function
REQ-010 SHALL implement states IDLE, REQUEST, DRAIN, FAULT.
REQ-011 IDLE: mem_read=0; next cycle enter REQUEST when buffer count (after this cycle's pop) < BUFFER_DEPTH and flush=0.
REQ-012 On REQUEST entry, mem_address SHALL latch fetch_address; mem_read=1 with mem_address stable until mem_ready sampled 1.
REQ-013 mem_read && mem_ready SHALL push {mem_address, mem_rdata} and pulse pc_write the same cycle; entry visible on instruction outputs the following cycle (latency 1).
REQ-014 After a push, SHALL remain in REQUEST (new request next cycle) if count < BUFFER_DEPTH after push, else go IDLE.
REQ-015 instruction_valid SHALL equal (count != 0); instruction/instruction_pc SHALL show the oldest entry.
REQ-016 Pop occurs when instruction_valid && decode_ready; simultaneous push and pop at full SHALL leave count unchanged.
REQ-017 flush=1 SHALL clear buffer (instruction_valid=0 next cycle) and suppress pc_write that cycle.
REQ-018 flush while mem_read=1 and mem_ready=0 SHALL go DRAIN: mem_read held, returned data discarded without pc_write, then REQUEST.
REQ-019 flush coincident with mem_ready SHALL discard that data, no pc_write, next state REQUEST.
REQ-020 flush in IDLE or FAULT SHALL go REQUEST next cycle; fetch_fault cleared.
REQ-021 Buffer read/write pointers SHALL wrap modulo BUFFER_DEPTH; count width clog2(BUFFER_DEPTH)+1.

Reset
REQ-022 reset=0 SHALL immediately force: state IDLE, count 0, pointers 0, mem_read 0, mem_address 0, pc_write 0, instruction 0, instruction_pc 0, instruction_valid 0, fetch_fault 0.
REQ-023 Reset mid-request SHALL drop mem_read without waiting for mem_ready; first request issues second cycle after deassertion.

Configuration
REQ-024 Macro FETCH_MISALIGN_TRAP_EN defined: request launch with fetch_address[1:0]!=0 SHALL not assert mem_read, SHALL enter FAULT, fetch_fault=1 held until flush or reset.
REQ-025 Macro undefined: mem_address[1:0] SHALL be forced to 00, FAULT state unreachable, fetch_fault tied 0 (port retained).

Structure
REQ-026 Package fetch_pkg SHALL hold fetch state enum, fetch entry struct (pc, instruction), default depth constant.
REQ-027 Buffer SHALL be sub-module fetch_fifo (push/pop/flush, full/empty, count); FSM and handshake remain in instruction_fetch.

Verification
REQ-028 Reset release, fetch_address=0x00000000, mem_ready=1 always, decode_ready=1 -> mem_read cycle 2, pc_write every cycle, instruction_pc 0x0,0x4,0x8 in order.
REQ-029 decode_ready=0, BUFFER_DEPTH=2 -> exactly 2 pushes, then mem_read=0, count=2; decode_ready=1 -> fetching resumes, no entry lost or duplicated.
REQ-030 mem_ready delayed 3 cycles, flush at cycle 1 of wait -> DRAIN, returned 0xDEADBEEF never appears, no pc_write, next request uses new fetch_address 0x00000100.
REQ-031 flush same cycle as mem_ready with buffer holding 1 entry -> instruction_valid=0 next cycle, pc_write=0.
REQ-032 With FETCH_MISALIGN_TRAP_EN, fetch_address=0x00000102 -> mem_read stays 0, fetch_fault=1 until flush; without macro -> mem_address=0x00000100, fetch_fault=0.
REQ-033 reset asserted while mem_read=1 -> all outputs zero immediately, asynchronously, mid-cycle.
